// File: rtl/aes_pkg.sv
// Shared AES definitions: key/block sizes and the frame-builder state encoding.
package aes_pkg;

    localparam int AES256_KEY_LENGTH = 256;
    localparam int AES_BLOCK_SIZE    = 128;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_KEY     = 5'b00010,
        ST_IV      = 5'b00100,
        ST_PAYLOAD = 5'b01000,
        ST_DRAIN   = 5'b10000
    } fb_state_e;

    function automatic int words_per(input int bits, input int width);
        return bits / width;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle (tdata/tkeep/tlast/tuser/tvalid/tready) with master and slave views.
interface axis_if #(
    parameter int AXIS_WIDTH = 8
);
    logic [AXIS_WIDTH-1:0]   tdata;
    logic [AXIS_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/aes_axis_out_reg.sv
// One-deep registered AXI-Stream output stage; accepts a new beat whenever it is
// empty or its current beat is being taken downstream in the same cycle.
module aes_axis_out_reg #(
    parameter int AXIS_WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    load_i,
    input  logic [AXIS_WIDTH-1:0]   tdata_i,
    input  logic [AXIS_WIDTH/8-1:0] tkeep_i,
    input  logic                    tlast_i,
    input  logic                    tuser_i,
    output logic                    can_load_o,
    axis_if.master                  M_axis
);

    logic                    valid_q;
    logic [AXIS_WIDTH-1:0]   tdata_q;
    logic [AXIS_WIDTH/8-1:0] tkeep_q;
    logic                    tlast_q;
    logic                    tuser_q;

    assign can_load_o = !valid_q || M_axis.tready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_q <= 1'b0;
            tdata_q <= '0;
            tkeep_q <= '0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
        end else if (load_i && can_load_o) begin
            valid_q <= 1'b1;
            tdata_q <= tdata_i;
            tkeep_q <= tkeep_i;
            tlast_q <= tlast_i;
            tuser_q <= tuser_i;
        end else if (M_axis.tready) begin
            valid_q <= 1'b0;
            tdata_q <= '0;
            tkeep_q <= '0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
        end
    end

    assign M_axis.tvalid = valid_q;
    assign M_axis.tdata  = tdata_q;
    assign M_axis.tkeep  = tkeep_q;
    assign M_axis.tlast  = tlast_q;
    assign M_axis.tuser  = tuser_q;

endmodule

// File: rtl/aes_ctr_frame_builder.sv
// Frames key words, counter (IV) words and payload into the AES-256 CTR core stream.
// Optional AES_FRAME_STATS_EN adds Frame_cnt/Byte_cnt counters on the output side.
module aes_ctr_frame_builder
    import aes_pkg::*;
#(
    parameter int AXIS_WIDTH = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Cfg_valid,
    output logic                         Cfg_ready,
    input  logic [AES256_KEY_LENGTH-1:0] Cfg_key,
    input  logic [AES_BLOCK_SIZE-1:0]    Cfg_iv,
    input  logic                         Cfg_encrypt,
    axis_if.slave                        S_axis,
    axis_if.master                       M_axis,
    output logic                         Busy
`ifdef AES_FRAME_STATS_EN
    ,
    output logic [31:0]                  Frame_cnt,
    output logic [31:0]                  Byte_cnt
`endif
);

    localparam int KEY_WORDS = words_per(AES256_KEY_LENGTH, AXIS_WIDTH);
    localparam int IV_WORDS  = words_per(AES_BLOCK_SIZE, AXIS_WIDTH);
    localparam int CNT_W     = $clog2(KEY_WORDS + 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_WORDS - 1);

    fb_state_e                    state_q;
    logic [CNT_W-1:0]             word_cnt_q;
    logic [AES256_KEY_LENGTH-1:0] key_q;
    logic [AES_BLOCK_SIZE-1:0]    iv_q;
    logic                         encrypt_q;

    logic                    can_load;
    logic                    load;
    logic [AXIS_WIDTH-1:0]   load_data;
    logic [AXIS_WIDTH/8-1:0] load_keep;
    logic                    load_last;
    logic                    s_fire;
    logic                    unused_s_tuser;

    assign Cfg_ready      = (state_q == ST_IDLE);
    assign Busy           = (state_q != ST_IDLE);
    assign S_axis.tready  = (state_q == ST_PAYLOAD) && can_load;
    assign s_fire         = S_axis.tvalid && S_axis.tready;
    assign unused_s_tuser = S_axis.tuser;

    // Key and IV are shifted down as words go out, so the next word is always
    // in the low AXIS_WIDTH bits and no wide word-select mux is needed.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        load      = 1'b0;
        load_data = key_q[AXIS_WIDTH-1:0];
        load_keep = '1;
        load_last = 1'b0;
        case (state_q)
            ST_KEY: load = can_load;
            ST_IV: begin
                load      = can_load;
                load_data = iv_q[AXIS_WIDTH-1:0];
            end
            ST_PAYLOAD: begin
                load      = S_axis.tvalid && can_load;
                load_data = S_axis.tdata;
                load_keep = S_axis.tkeep;
                load_last = S_axis.tlast;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            encrypt_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Cfg_valid) begin
                        key_q      <= Cfg_key;
                        iv_q       <= Cfg_iv;
                        encrypt_q  <= Cfg_encrypt;
                        word_cnt_q <= '0;
                        state_q    <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    if (can_load) begin
                        key_q <= key_q >> AXIS_WIDTH;
                        if (word_cnt_q == KEY_LAST) begin
                            word_cnt_q <= '0;
                            state_q    <= ST_IV;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                ST_IV: begin
                    if (can_load) begin
                        iv_q <= iv_q >> AXIS_WIDTH;
                        if (word_cnt_q == IV_LAST) begin
                            word_cnt_q <= '0;
                            state_q    <= ST_PAYLOAD;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (s_fire && S_axis.tlast) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // The register can accept a beat only once the tlast beat has left.
                    if (can_load) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    aes_axis_out_reg #(
        .AXIS_WIDTH(AXIS_WIDTH)
    ) u_out_reg (
        .Clk       (Clk),
        .Rst       (Rst),
        .load_i    (load),
        .tdata_i   (load_data),
        .tkeep_i   (load_keep),
        .tlast_i   (load_last),
        .tuser_i   (encrypt_q),
        .can_load_o(can_load),
        .M_axis    (M_axis)
    );

`ifdef AES_FRAME_STATS_EN
    logic        payload_beat_q;
    logic [31:0] frame_cnt_q;
    logic [31:0] byte_cnt_q;
    logic        m_fire;

    assign m_fire = M_axis.tvalid && M_axis.tready;

    // payload_beat_q tags the beat held in the output register so key/IV bytes
    // are kept out of the byte count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            payload_beat_q <= 1'b0;
            frame_cnt_q    <= '0;
            byte_cnt_q     <= '0;
        end else begin
            if (load) payload_beat_q <= (state_q == ST_PAYLOAD);
            if (m_fire && M_axis.tlast) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (m_fire && payload_beat_q) byte_cnt_q <= byte_cnt_q + 32'($countones(M_axis.tkeep));
        end
    end

    assign Frame_cnt = frame_cnt_q;
    assign Byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_aes_ctr_frame_builder.sv
// Scoreboard bench: frame stimulus pushes expected output beats, a negedge monitor pops and compares.
module tb_aes_ctr_frame_builder;

    localparam int W  = 32;
    localparam int KW = 256 / W;
    localparam int IW = 128 / W;
    localparam int KB = W / 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KB-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [255:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         cfg_encrypt = 1'b0;
    logic         busy;
`ifdef AES_FRAME_STATS_EN
    logic [31:0]  frame_cnt;
    logic [31:0]  byte_cnt;
`endif

    axis_if #(.AXIS_WIDTH(W)) s_if ();
    axis_if #(.AXIS_WIDTH(W)) m_if ();

    aes_ctr_frame_builder #(.AXIS_WIDTH(W)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Cfg_valid  (cfg_valid),
        .Cfg_ready  (cfg_ready),
        .Cfg_key    (cfg_key),
        .Cfg_iv     (cfg_iv),
        .Cfg_encrypt(cfg_encrypt),
        .S_axis     (s_if),
        .M_axis     (m_if),
        .Busy       (busy)
`ifdef AES_FRAME_STATS_EN
        ,
        .Frame_cnt  (frame_cnt),
        .Byte_cnt   (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t pay_q[$];
    int    trdy_mode = 0;
    bit    gap_en = 0;
    bit    perf_en = 0;
    int    perf_len = 0;
    int    cyc = 0;
    int    cfg_cyc = 0;
    int    frame_beats = 0;
    bit    idle_pending = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;
    logic [31:0] exp_frames = 0;
    logic [31:0] exp_bytes = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int waited);
        checks++;
        errors++;
        $display("FAIL timeout %s: waited %0d cycles without the event", name, waited);
    endtask

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = held low.
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (trdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Monitor: every check looks at values that are settled half a cycle before the edge.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cyc++;
        cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
        if (rst) begin
            prev_stall   = 0;
            idle_pending = 0;
        end else begin
            if (idle_pending) begin
                check("busy after last beat", busy, 0);
                check("cfg_ready after last beat", cfg_ready, 1);
                idle_pending = 0;
            end
            if (prev_stall) begin
                check("stalled tvalid held", m_if.tvalid, 1);
                check("stalled beat stable", cur, prev_beat);
            end
            if (cfg_ready) check("s_tready low while idle", s_if.tready, 0);
            if (cfg_valid && cfg_ready) begin
                cfg_cyc     = cyc;
                frame_beats = 0;
            end
            if (s_if.tvalid && s_if.tready)
                check("payload accepted only after key/iv", frame_beats >= KW + IW - 1, 1);
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got %0h, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("m_axis beat", cur, e);
                end
                frame_beats++;
                if (cur.last) begin
                    idle_pending = 1;
                    if (perf_en) check("frame cycle count", cyc - cfg_cyc, perf_len);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = cur;
        end
    end

    task automatic drive_cfg(input logic [255:0] k, input logic [127:0] iv, input logic enc);
        bit acc;
        int n = 0;
        cfg_key     = k;
        cfg_iv      = iv;
        cfg_encrypt = enc;
        cfg_valid   = 1'b1;
        do begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 3000);
        cfg_valid = 1'b0;
        if (!acc) timeout_fail("cfg handshake", n);
    endtask

    task automatic drive_payload();
        beat_t b;
        bit    acc;
        int    n;
        while (pay_q.size() != 0) begin
            b = pay_q.pop_front();
            if (gap_en && $urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = b.data;
            s_if.tkeep  = b.keep;
            s_if.tlast  = b.last;
            n = 0;
            do begin
                @(negedge clk);
                acc = s_if.tready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 3000);
            if (!acc) begin
                timeout_fail("payload handshake", n);
                pay_q.delete();
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            timeout_fail("frame drain", n);
            exp_q.delete();
        end
    endtask

    // Reference model: the output stream is the key split into words (LSB first),
    // the IV likewise, then the payload beats unchanged; tuser is the frame's direction.
    task automatic push_key_iv(input logic [255:0] k, input logic [127:0] iv, input logic enc);
        for (int i = 0; i < KW; i++) exp_q.push_back({W'(k >> (i * W)), {KB{1'b1}}, 1'b0, enc});
        for (int i = 0; i < IW; i++) exp_q.push_back({W'(iv >> (i * W)), {KB{1'b1}}, 1'b0, enc});
    endtask

    task automatic run_frame(input logic [255:0] k, input logic [127:0] iv, input logic enc,
                             input int nb, input logic [KB-1:0] last_keep,
                             input int cfg_delay, input bit perf);
        beat_t b;
        push_key_iv(k, iv, enc);
        for (int i = 0; i < nb; i++) begin
            b.data = W'($urandom());
            b.keep = (i == nb - 1) ? last_keep : {KB{1'b1}};
            b.last = (i == nb - 1);
            b.user = enc;
            pay_q.push_back(b);
            exp_q.push_back(b);
            exp_bytes += 32'($countones(b.keep));
        end
        exp_frames += 1;
        perf_en  = perf;
        perf_len = KW + IW + nb + 1;
        fork
            begin
                repeat (cfg_delay) begin
                    @(posedge clk);
                    #1;
                end
                drive_cfg(k, iv, enc);
            end
            drive_payload();
        join
        wait_idle();
        perf_en = 0;
    endtask

    initial begin
        logic [255:0] k0;
        logic [127:0] iv0;
        logic [255:0] kr;
        logic [127:0] ivr;
        int           n;

        for (int i = 0; i < 32; i++) k0[i*8 +: 8] = 8'(i);
        iv0 = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;

        #2 rst = 1'b1;
        #1;
        check("reset tvalid", m_if.tvalid, 0);
        check("reset tdata/tkeep/tlast/tuser", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, 0);
        check("reset busy", busy, 0);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        check("cfg_ready after reset", cfg_ready, 1);

        // Fixed frame, downstream always ready: 14 back-to-back beats.
        trdy_mode = 0;
        run_frame(k0, iv0, 1'b1, 2, 4'hF, 0, 1'b1);

        // Same frame under random backpressure.
        trdy_mode = 1;
        run_frame(k0, iv0, 1'b1, 2, 4'hF, 0, 1'b0);

        // Payload presented well before the config.
        trdy_mode = 0;
        run_frame(k0, iv0, 1'b0, 4, 4'hF, 5, 1'b1);

        // Lone tlast beat with a partial keep.
        run_frame(k0, iv0, 1'b1, 1, 4'h3, 0, 1'b1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) kr[i*32 +: 32] = $urandom();
            for (int i = 0; i < 4; i++) ivr[i*32 +: 32] = $urandom();
            trdy_mode = $urandom_range(0, 1);
            gap_en    = 1'($urandom_range(0, 1));
            run_frame(kr, ivr, 1'($urandom_range(0, 1)), $urandom_range(1, 6),
                      KB'($urandom_range(1, (1 << KB) - 1)), $urandom_range(0, 3), 1'b0);
        end
        gap_en = 0;

        // Reset while stalled in the IV phase.
        trdy_mode = 0;
        push_key_iv(k0, iv0, 1'b1);
        drive_cfg(k0, iv0, 1'b1);
        n = 0;
        while (frame_beats < KW + 1 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) timeout_fail("iv phase reached", n);
        trdy_mode = 2;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stalled mid-frame busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset tvalid", m_if.tvalid, 0);
        check("async reset beat fields", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, 0);
        check("async reset busy", busy, 0);
        check("async reset s_tready", s_if.tready, 0);
        exp_q.delete();
        exp_frames = 0;
        exp_bytes  = 0;
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        trdy_mode = 0;
        check("cfg_ready after mid-frame reset", cfg_ready, 1);

        // Restart after reset: frames of 5, 16 and 1 payload bytes.
        run_frame(k0, iv0, 1'b0, 2, 4'h1, 0, 1'b1);
        trdy_mode = 1;
        run_frame(k0, iv0, 1'b1, 4, 4'hF, 1, 1'b0);
        trdy_mode = 0;
        run_frame(k0, iv0, 1'b0, 1, 4'h1, 0, 1'b1);
`ifdef AES_FRAME_STATS_EN
        check("frame_cnt", frame_cnt, exp_frames);
        check("byte_cnt", byte_cnt, exp_bytes);
`endif
        check("scoreboard drained", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
